y86_decode: RTL and testbench



---
 rtl/y86_decode.sv | 107 ++++++++++
 tb/tb_y86_decode.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/y86_decode.sv
// y86_decode -- decode stage of the sequential Y86-64 processor.
//
// Holds the 15-entry x 64-bit program register file and reads the two
// source operands selected by the instruction code. The register file is
// never written by this block: reset loads R[i] = i and the contents then
// hold until the next reset.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   icode  in   4  instruction code from fetch
//   rA     in   4  register specifier A (4'hF = none)
//   rB     in   4  register specifier B (4'hF = none)
//   valA   out 64  operand A, registered
//   valB   out 64  operand B, registered
module y86_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  output logic [63:0] valA,
  output logic [63:0] valB
);

  localparam int          DATA_W = 64;
  localparam int          NREGS  = 15;
  localparam logic [3:0]  RNONE  = 4'hF;
  localparam logic [3:0]  RRSP   = 4'h4;

  localparam logic [3:0]  I_RRMOVQ = 4'h2;
  localparam logic [3:0]  I_RMMOVQ = 4'h4;
  localparam logic [3:0]  I_MRMOVQ = 4'h5;
  localparam logic [3:0]  I_OPQ    = 4'h6;
  localparam logic [3:0]  I_CALL   = 4'h8;
  localparam logic [3:0]  I_RET    = 4'h9;
  localparam logic [3:0]  I_PUSHQ  = 4'hA;
  localparam logic [3:0]  I_POPQ   = 4'hB;

  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]        srca;
  logic [3:0]        srcb;
  logic [DATA_W-1:0] rda;
  logic [DATA_W-1:0] rdb;
  logic [DATA_W-1:0] vala_p0;
  logic [DATA_W-1:0] valb_p0;

  // Each entry only ever takes its reset value; with no write port the
  // flops simply hold between resets.
  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[g] <= DATA_W'(g);
      end
    end
  end

  // Read port: specifier 15 (none) returns zero. The loop compare keeps the
  // array index in range for every value of the 4-bit specifier.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx,
                                               input logic [DATA_W-1:0] rf [NREGS]);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == 4'(i)) begin
        r = rf[i];
      end
    end
    return r;
  endfunction

  always_comb begin
    srca = RNONE;
    srcb = RNONE;
    case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srca = rA;
      I_RET, I_POPQ:                      srca = RRSP;
      default:                            srca = RNONE;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcb = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcb = RRSP;
      default:                            srcb = RNONE;
    endcase
  end

  always_comb begin
    rda = rd_reg(srca, regs);
    rdb = rd_reg(srcb, regs);
  end

  // ---- stage p0: operand registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vala_p0 <= '0;
      valb_p0 <= '0;
    end else begin
      vala_p0 <= rda;
      valb_p0 <= rdb;
    end
  end

  assign valA = vala_p0;
  assign valB = valb_p0;

endmodule

// File: tb/tb_y86_decode.sv
// Self-checking bench for y86_decode: directed cases with literal
// expectations plus randomized instructions checked every cycle against a
// behavioural model of the ISA operand rules.
module tb_y86_decode;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valA;
  logic [63:0] valB;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_a;
  logic [63:0] exp_b;

  y86_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .rA    (rA),
    .rB    (rB),
    .valA  (valA),
    .valB  (valB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file contents after reset: R[i] = i, none (15) reads as 0.
  function automatic logic [63:0] reg_value(input logic [3:0] r);
    if (r == 4'd15) return 64'd0;
    return 64'(r);
  endfunction

  function automatic logic [63:0] model_a(input logic [3:0] ic, input logic [3:0] a);
    if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return reg_value(a);
    if (ic inside {4'd9, 4'd11}) return reg_value(4'd4);
    return 64'd0;
  endfunction

  function automatic logic [63:0] model_b(input logic [3:0] ic, input logic [3:0] b);
    if (ic inside {4'd4, 4'd5, 4'd6}) return reg_value(b);
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return reg_value(4'd4);
    return 64'd0;
  endfunction

  // Reference: outputs are the model values of the inputs seen at the last
  // rising edge, or zero while/after reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a <= 64'd0;
      exp_b <= 64'd0;
    end else begin
      exp_a <= model_a(icode, rA);
      exp_b <= model_b(icode, rB);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (valA !== exp_a) begin
      errors++;
      $display("FAIL model_valA t=%0t actual=%0h required=%0h", $time, valA, exp_a);
    end
    checks++;
    if (valB !== exp_b) begin
      errors++;
      $display("FAIL model_valB t=%0t actual=%0h required=%0h", $time, valB, exp_b);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic step(input string name, input logic [3:0] ic, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] ea, input logic [63:0] eb);
    @(negedge clk);
    icode = ic;
    rA    = a;
    rB    = b;
    @(posedge clk);
    #1;
    chk({name, "_valA"}, valA, ea);
    chk({name, "_valB"}, valB, eb);
  endtask

  initial begin
    rst_n = 1'b0;
    icode = 4'd0;
    rA    = 4'd0;
    rB    = 4'd0;
    #12;
    chk("reset_valA", valA, 64'd0);
    chk("reset_valB", valB, 64'd0);
    #1 rst_n = 1'b1;

    step("rrmov_r0", 4'd2,  4'd0,  4'd0,  64'd0,  64'd0);
    step("rmmov",    4'd4,  4'd3,  4'd4,  64'd3,  64'd4);
    step("irmov",    4'd3,  4'd1,  4'd2,  64'd0,  64'd0);
    step("mrmov",    4'd5,  4'd4,  4'd10, 64'd0,  64'd10);
    step("opq",      4'd6,  4'd11, 4'd5,  64'd11, 64'd5);
    step("jxx",      4'd7,  4'd6,  4'd7,  64'd0,  64'd0);
    step("call",     4'd8,  4'd3,  4'd15, 64'd0,  64'd4);
    step("ret",      4'd9,  4'd15, 4'd15, 64'd4,  64'd4);
    step("pushq",    4'd10, 4'd9,  4'd15, 64'd9,  64'd4);
    step("popq",     4'd11, 4'd2,  4'd15, 64'd4,  64'd4);
    step("opq_none", 4'd6,  4'd15, 4'd15, 64'd0,  64'd0);
    step("invalid",  4'd13, 4'd1,  4'd2,  64'd0,  64'd0);
    step("opq_r14",  4'd6,  4'd14, 4'd14, 64'd14, 64'd14);
    step("halt",     4'd0,  4'd5,  4'd6,  64'd0,  64'd0);
    step("nop",      4'd1,  4'd5,  4'd6,  64'd0,  64'd0);
    step("inv_f",    4'd15, 4'd3,  4'd3,  64'd0,  64'd0);

    // Mid-cycle input change must not reach the outputs before the edge.
    step("pre_hold", 4'd6,  4'd3,  4'd5,  64'd3,  64'd5);
    #2;
    icode = 4'd6;
    rA    = 4'd7;
    rB    = 4'd8;
    #1;
    chk("hold_valA", valA, 64'd3);
    chk("hold_valB", valB, 64'd5);
    @(posedge clk);
    #1;
    chk("after_hold_valA", valA, 64'd7);
    chk("after_hold_valB", valB, 64'd8);

    // Asynchronous reset between edges clears nonzero outputs at once.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valA", valA, 64'd0);
    chk("async_rst_valB", valB, 64'd0);
    #2 rst_n = 1'b1;
    step("post_rst", 4'd10, 4'd12, 4'd0, 64'd12, 64'd4);

    // Randomized instructions; the negedge process checks each cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      icode = 4'($urandom_range(0, 15));
      rA    = 4'($urandom_range(0, 15));
      rB    = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
